// File: rtl/alu_op_sequencer.sv
// Issue/capture stage around a 32-bit ripple-carry adder: launches registered
// operands, waits SETTLE_CYCLES for the carry chain, then captures sum, flags and overflow.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [3:0]       in_func,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_f,
  input  logic [31:0]      alu_s,
  input  logic             alu_c,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETTLE = 2'd1, S_HOLD = 2'd2} state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the sender holds its payload stable until that edge.

  state_t             r_state;
  state_t             w_next_state;
  logic [3:0]         r_cnt;
  logic [31:0]        r_alu_a;
  logic [31:0]        r_alu_b;
  logic [3:0]         r_alu_f;
  logic               r_out_valid;
  logic [31:0]        r_out_result;
  logic               r_out_carry;
  logic               r_out_zero;
  logic               r_out_neg;
  logic               r_out_ovf;
  logic [CNT_W-1:0]   r_op_count;

  logic               w_accept;
  logic               w_capture;
  logic               w_handoff;
  logic               w_amod_msb;
  logic               w_bmod_msb;
  logic               w_arith;
  logic               w_ovf;

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_capture = (r_state == S_SETTLE) && (r_cnt == 4'd1);
  assign w_handoff = (r_state == S_HOLD) && r_out_valid && out_ready;

  // Overflow is judged on the operands the adder actually sums, not on raw A/B.
  assign w_arith    = r_alu_f[2];
  assign w_amod_msb = r_alu_f[1] ? 1'b0 : r_alu_a[31];
  assign w_bmod_msb = r_alu_b[31] ^ (r_alu_f[0] ^ r_alu_f[1]);
  assign w_ovf      = w_arith && (w_amod_msb == w_bmod_msb) && (alu_s[31] != w_amod_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept)  w_next_state = S_SETTLE;
      S_SETTLE: if (w_capture) w_next_state = S_HOLD;
      S_HOLD:   if (w_handoff) w_next_state = S_IDLE;
      default:                 w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 4'd0;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_alu_f      <= 4'd0;
      r_out_valid  <= 1'b0;
      r_out_result <= 32'd0;
      r_out_carry  <= 1'b0;
      r_out_zero   <= 1'b0;
      r_out_neg    <= 1'b0;
      r_out_ovf    <= 1'b0;
      r_op_count   <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a <= in_a;
        r_alu_b <= in_b;
        r_alu_f <= in_func;
        r_cnt   <= LP_SETTLE;
      end else if (r_state == S_SETTLE) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_out_valid  <= 1'b1;
        r_out_result <= alu_s;
        r_out_carry  <= w_arith && alu_c;
        r_out_zero   <= alu_zero;
        r_out_neg    <= alu_neg;
        r_out_ovf    <= w_ovf;
      end else if (w_handoff) begin
        r_out_valid <= 1'b0;
        r_op_count  <= r_op_count + CNT_W'(1);
      end
    end
  end

  // Gated by rst_n so the upstream never sees ready while reset is held.
  assign in_ready   = (r_state == S_IDLE) && rst_n;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_f      = r_alu_f;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_carry  = r_out_carry;
  assign out_zero   = r_out_zero;
  assign out_neg    = r_out_neg;
  assign out_ovf    = r_out_ovf;
  assign op_count   = r_op_count;
  assign dbg_state  = r_state;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Registered issue/capture stage wrapped around the 32-bit ripple-carry arithmetic unit.
- Accepts one operation per valid/ready handshake and holds operands and function code stable on the adder inputs.
- Waits a programmable number of cycles for the gate-delayed carry chain to settle, then captures the sum and flags into output registers.
- Computes the overflow flag, which the adder does not produce.

Parameters:
- SETTLE_CYCLES, 4, clock cycles between operand launch and result capture; legal range 1..15.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operation request.
- in_ready  output  1  sequencer can accept a request.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- in_func  input  4  function code {f3,f2,f1,f0}.
- alu_a  output  32  registered operand A to adder.
- alu_b  output  32  registered operand B to adder.
- alu_f  output  4  registered function code to adder.
- alu_s  input  32  adder sum.
- alu_c  input  1  adder carry-out.
- alu_zero  input  1  adder zero flag.
- alu_neg  input  1  adder negative flag.
- out_valid  output  1  captured result available.
- out_ready  input  1  downstream accepts result.
- out_result  output  32  captured sum.
- out_carry  output  1  captured carry.
- out_zero  output  1  captured zero.
- out_neg  output  1  captured negative.
- out_ovf  output  1  computed signed overflow.
- op_count  output  CNT_W  completed (handed-off) operations, wraps.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All alu_* and out_* registers = 0; op_count = 0; settle counter = 0.
  - in_ready = 0 while rst_n is low; 1 from the first cycle after deassertion.
- Function decode (f2=1 arithmetic; f3 ignored):
  - f1f0=00: A+B.
  - 01: A-B.
  - 10: -B.
  - 11: B+1.
- Effective operands:
  - Amod = f1 ? 0 : A.
  - Bmod = B XOR {32{f0^f1}}.
  - cin = f1|f0.
- Overflow:
  - out_ovf = (Amod[31]==Bmod[31]) && (alu_s[31]!=Amod[31]), evaluated at capture.
  - When f2=0 (boolean path), out_carry and out_ovf are forced to 0; out_result, out_zero and out_neg are still captured from the adder.
- FSM:
  - IDLE:
    - in_ready=1.
    - On in_valid: register in_a/in_b/in_func into alu_a/alu_b/alu_f, load counter=SETTLE_CYCLES, go to SETTLE.
  - SETTLE:
    - in_ready=0; counter decrements each edge.
    - On the edge where counter==1: capture alu_s, alu_c, alu_zero, alu_neg and the computed ovf; set out_valid=1; go to HOLD.
  - HOLD:
    - in_ready=0; out_* stable.
    - On out_valid&&out_ready: out_valid=0, op_count+1, go to IDLE.
- Latency:
  - Accepted at edge k → out_valid=1 after edge k+SETTLE_CYCLES.
  - Minimum issue interval is SETTLE_CYCLES+2 cycles with out_ready=1.
- alu_a/alu_b/alu_f hold their values from acceptance until the next acceptance; they are never changed during SETTLE or HOLD.
- out_* registers hold their values after handoff until the next capture.
- in_valid during SETTLE/HOLD is ignored (no capture, no loss flagged); upstream must hold the request.
- out_ready asserted outside HOLD has no effect.
- op_count wraps from 2^CNT_W-1 to 0.
- Reset mid-SETTLE or mid-HOLD: in-flight op discarded, op_count not incremented, all outputs take reset values immediately (async).
- SETTLE_CYCLES=1: capture on the first edge after acceptance.

Test Plan:
- Add, in_a=1, in_b=1, in_func=4'b0100, out_ready=1 → after 4 cycles out_result=0x00000002, C=0, Z=0, N=0, V=0; op_count=1.
- Subtract, in_a=1, in_b=1, func=4'b0101 → out_result=0, Z=1, C=1, N=0, V=0.
- Overflow, in_a=0x7FFFFFFF, in_b=1, func=4'b0100 → out_result=0x80000000, N=1, V=1, C=0. Negate, in_b=5, func=4'b0110 → 0xFFFFFFFB, N=1, C=0, V=0.
- Increment wrap, in_b=0xFFFFFFFF, func=4'b0111 → out_result=0, Z=1, C=1, V=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles after out_valid, with in_valid held high and new operands presented.
  - Required: in_ready=0, out_* and alu_* unchanged.
  - Release → handoff, then the new op is accepted the next cycle.
- Reset mid-SETTLE:
  - Pulse rst_n low 2 cycles after acceptance.
  - Required: out_valid=0, alu_*=0, op_count unchanged at 0, in_ready=1 the cycle after release.
  - Latency check with SETTLE_CYCLES=1 and SETTLE_CYCLES=15.
